r2sdf_stage: RTL and testbench
==============================

// Module: r2sdf_stage
// PURPOSE
//  Radix-2 single-delay-feedback (R2SDF) butterfly stage of the pipelined FFT.
//  Sits directly upstream of the complex multiplier: emits butterfly sums/differences
//  plus the twiddle index that the twiddle ROM + complex multiplier consume.
//  One stage per FFT level; DELAY = N/2 at first stage, halves per stage.
// PARAMETERS
//  WIDTH       16  signed two's-complement width of each re/im component
//  DELAY        8  feedback delay depth (half the block length handled by this stage); power of 2, >=2
//  LOG2_DELAY   3  log2(DELAY); twiddle index and counter width derive from it
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous reset, active low
//  in_valid   in   1           input sample present this cycle; no backpressure
//  in_re      in   WIDTH       input real (signed)
//  in_im      in   WIDTH       input imag (signed)
//  out_valid  out  1           output sample valid
//  out_re     out  WIDTH       output real (signed)
//  out_im     out  WIDTH       output imag (signed)
//  out_sop    out  1           first output of a 2*DELAY block (with out_valid)
//  tw_addr    out  LOG2_DELAY  twiddle exponent k for W^k applied downstream; 0 for sums
// BEHAVIOUR
//  - One clock (clk); reset asynchronous, active low (rst_n). Reset: out_valid=0, out_sop=0,
//    out_re=out_im=0, tw_addr=0, counter=0, primed=0; delay-line contents need not reset.
//  - cnt: LOG2_DELAY+1 bits, +1 (wrap mod 2*DELAY) per accepted sample only (in_valid=1).
//    phase = cnt[LOG2_DELAY]; j = cnt[LOG2_DELAY-1:0]. head = oldest delay-line entry.
//  - Phase 0 (fill): out <= head; delay-line push in; tw_addr <= j.
//  - Phase 1 (butterfly): out <= head + in; delay-line push head - in; tw_addr <= 0.
//  - Latency: 1 cycle in_valid -> out_valid; all outputs registered.
//  - out_valid <= in_valid & (phase | primed); primed <= primed | (in_valid & phase).
//    So phase-0 outputs of the first block after reset (stale delay contents) are suppressed.
//  - out_sop <= in_valid & (cnt == DELAY) & ... i.e. asserted with the first phase-1 output of each block.
//  - in_valid=0: cnt, delay line, primed hold; out_valid=0 next cycle; out data holds last value.
//  - Gaps in in_valid anywhere (mid-phase, at wrap) are legal and change no results.
//  - Tail: last block's differences stay in the delay line until next block's phase 0 pushes them out.
//  - Arithmetic: add/sub at WIDTH+1 bits; result then narrowed per CONFIGURATION.
//  - Reset mid-block: block discarded; cnt=0, primed=0; first post-reset data treated as new block start.
// CONFIGURATION
//  Macro R2SDF_SCALE_EN:
//   defined   : both sum and difference scaled by 1/2 with round-half-up: (x + 1) >>> 1 on WIDTH+1 bits;
//               phase-0 pass-through not scaled (its content was already scaled when pushed).
//   undefined : result truncated to low WIDTH bits (two's-complement wrap); caller guarantees headroom.
// STRUCTURE
//  - Package fft_pkg: default WIDTH/FIXED_POINT, phase encoding (PH_FILL=0, PH_BFLY=1),
//    function for the scale/narrow step (shared with later stages).
//  - Sub-module sdf_delay_line (WIDTH*2 bits wide, DELAY deep): circular buffer with one
//    pointer, read-old/write-new in the same enabled cycle; enable = in_valid.
//  - Top: counter, primed flag, butterfly adders, output registers.
// TESTING (DELAY=4, WIDTH=16, macro undefined unless stated)
//  1 Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out_sop=0, outputs 0; release mid-cycle OK.
//  2 Block re=1..8, im=0 contiguous -> first out_valid on 5th input+1 cycle; sums 6,8,10,12 (tw 0,
//    out_sop on first); then next block's phase 0 emits diffs -4,-4,-4,-4 with tw_addr 0,1,2,3.
//  3 Same stream with in_valid toggled 1,0,1,0 -> identical output sequence, out_valid only after accepts.
//  4 R2SDF_SCALE_EN: in 0x7FFF at j and j+4 -> sum 0x7FFF (no wrap), diff 0; without macro sum wraps to 0xFFFE.
//  5 Reset asserted after 6 inputs, then new block 1..8 -> output matches test 2 exactly (no stale data).
//  6 Random 64 blocks vs. golden radix-2 DIF stage model (incl. tw_addr) -> bit-exact match.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT types, defaults and the scale/narrow step (R2SDF_SCALE_EN selects halving)
package fft_pkg;
    localparam int DEFAULT_WIDTH = 16;
    localparam int FIXED_POINT   = 15;
    localparam int MAX_W         = 32;

    typedef enum logic {PH_FILL = 1'b0, PH_BFLY = 1'b1} phase_e;

    // x is a sign-extended WIDTH+1 result; callers keep the low WIDTH bits of the return value
    function automatic logic [MAX_W-1:0] narrow(input logic signed [MAX_W:0] x);
`ifdef R2SDF_SCALE_EN
        logic signed [MAX_W:0] r;
        r = (x + 33'sd1) >>> 1;
        return r[MAX_W-1:0];
`else
        return x[MAX_W-1:0];
`endif
    endfunction
endpackage

// File: rtl/sdf_delay_line.sv
// sdf_delay_line: circular delay buffer, reads the oldest entry and overwrites it when enabled
module sdf_delay_line #(
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ptr_q;

    assign rdata_o = mem[ptr_q];

    // storage is never reset: stale entries only ever reach suppressed outputs
    always_ff @(posedge clk) begin
        if (en_i) mem[ptr_q] <= wdata_i;
    end

    // pointer advances once per accepted sample and wraps naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else if (en_i) ptr_q <= ptr_q + 1'b1;
    end
endmodule

// File: rtl/r2sdf_stage.sv
// r2sdf_stage: radix-2 single-delay-feedback butterfly stage; R2SDF_SCALE_EN halves butterfly results
module r2sdf_stage
    import fft_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DELAY      = 8,
    parameter int LOG2_DELAY = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_re,
    input  logic [WIDTH-1:0]      in_im,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_re,
    output logic [WIDTH-1:0]      out_im,
    output logic                  out_sop,
    output logic [LOG2_DELAY-1:0] tw_addr
);
    logic [LOG2_DELAY:0]   cnt_q, cnt_d;
    logic                  primed_q, primed_d, valid_q, valid_d, sop_q, sop_d;
    logic [WIDTH-1:0]      re_q, re_d, im_q, im_d;
    logic [LOG2_DELAY-1:0] tw_q, tw_d, j;
    logic [2*WIDTH-1:0]    head, push;
    logic [WIDTH-1:0]      head_re, head_im;
    logic [WIDTH:0]        sum_re, sum_im, dif_re, dif_im;
    logic [MAX_W-1:0]      n_sre, n_sim, n_dre, n_dim;
    logic                  bfly;
    phase_e                phase;
    logic                  unused_hi;

    function automatic logic signed [MAX_W:0] sx(input logic [WIDTH:0] v);
        return {{(MAX_W-WIDTH){v[WIDTH]}}, v};
    endfunction

    sdf_delay_line #(.DW(2*WIDTH), .DEPTH(DELAY), .AW(LOG2_DELAY)) u_dl (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (in_valid),
        .wdata_i (push),
        .rdata_o (head)
    );

    assign phase   = phase_e'(cnt_q[LOG2_DELAY]);
    assign bfly    = (phase == PH_BFLY);
    assign j       = cnt_q[LOG2_DELAY-1:0];
    assign head_re = head[2*WIDTH-1:WIDTH];
    assign head_im = head[WIDTH-1:0];
    assign sum_re  = {head_re[WIDTH-1], head_re} + {in_re[WIDTH-1], in_re};
    assign sum_im  = {head_im[WIDTH-1], head_im} + {in_im[WIDTH-1], in_im};
    assign dif_re  = {head_re[WIDTH-1], head_re} - {in_re[WIDTH-1], in_re};
    assign dif_im  = {head_im[WIDTH-1], head_im} - {in_im[WIDTH-1], in_im};
    assign n_sre   = narrow(sx(sum_re));
    assign n_sim   = narrow(sx(sum_im));
    assign n_dre   = narrow(sx(dif_re));
    assign n_dim   = narrow(sx(dif_im));
    assign unused_hi = ^{n_sre[MAX_W-1:WIDTH], n_sim[MAX_W-1:WIDTH], n_dre[MAX_W-1:WIDTH], n_dim[MAX_W-1:WIDTH]};

    // fill phase forwards the head and stores the input; butterfly phase emits sums and stores differences
    always_comb begin
        push      = bfly ? {n_dre[WIDTH-1:0], n_dim[WIDTH-1:0]} : {in_re, in_im};
        cnt_d     = in_valid ? cnt_q + 1'b1 : cnt_q;
        primed_d  = primed_q | (in_valid & bfly);
        valid_d   = in_valid & (bfly | primed_q);
        sop_d     = in_valid & bfly & ~|j;
        re_d      = !in_valid ? re_q : bfly ? n_sre[WIDTH-1:0] : head_re;
        im_d      = !in_valid ? im_q : bfly ? n_sim[WIDTH-1:0] : head_im;
        tw_d      = !in_valid ? tw_q : bfly ? '0 : j;
    end

    // control and output registers; reset discards any partial block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            primed_q <= 1'b0;
            valid_q  <= 1'b0;
            sop_q    <= 1'b0;
            re_q     <= '0;
            im_q     <= '0;
            tw_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            valid_q  <= valid_d;
            sop_q    <= sop_d;
            re_q     <= re_d;
            im_q     <= im_d;
            tw_q     <= tw_d;
        end
    end

    assign out_valid = valid_q;
    assign out_sop   = sop_q;
    assign out_re    = re_q;
    assign out_im    = im_q;
    assign tw_addr   = tw_q;
endmodule

// File: tb/tb_r2sdf_stage.sv
// tb_r2sdf_stage: scoreboard bench for r2sdf_stage (DELAY=4, WIDTH=16), honours R2SDF_SCALE_EN
module tb_r2sdf_stage;
    localparam int W = 16;
    localparam int D = 4;
    localparam int L = 2;

    typedef struct packed {
        logic         v;
        logic         sop;
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic [L-1:0] tw;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_re = '0, in_im = '0;
    logic         out_valid, out_sop;
    logic [W-1:0] out_re, out_im;
    logic [L-1:0] tw_addr;

    obs_t        exp_q[$], got_q[$];
    logic [31:0] m_fifo[$];
    int          m_cnt;
    bit          m_primed;
    int          n_cmp = 0, n_bad = 0;

`ifdef R2SDF_SCALE_EN
    logic [W-1:0] ref_re [8] = '{16'd3, 16'd4, 16'd5, 16'd6, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE};
    logic [W-1:0] wrap_sum = 16'h7FFF;
`else
    logic [W-1:0] ref_re [8] = '{16'd6, 16'd8, 16'd10, 16'd12, 16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC};
    logic [W-1:0] wrap_sum = 16'hFFFE;
`endif
    logic [L-1:0] ref_tw [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};

    always #5 clk = ~clk;

    r2sdf_stage #(.WIDTH(W), .DELAY(D), .LOG2_DELAY(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_sop   (out_sop),
        .tw_addr   (tw_addr)
    );

    function automatic logic [W-1:0] nar(input int s);
        int t;
        t = s;
`ifdef R2SDF_SCALE_EN
        t = (t + 1) >>> 1;
`endif
        return t[W-1:0];
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_primed = 0;
        m_fifo = {};
        repeat (D) m_fifo.push_back('0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] re, input logic [W-1:0] im);
        obs_t e;
        logic [31:0] h;
        int hr, hi, ir, ii;
        e = '0;
        if (v) begin
            h = m_fifo.pop_front();
            hr = int'($signed(h[31:16]));
            hi = int'($signed(h[15:0]));
            ir = int'($signed(re));
            ii = int'($signed(im));
            if (m_cnt < D) begin
                e.v = m_primed;
                e.re = h[31:16];
                e.im = h[15:0];
                e.tw = L'(m_cnt);
                m_fifo.push_back({re, im});
            end else begin
                e.v = 1'b1;
                e.sop = (m_cnt == D);
                e.re = nar(hr + ir);
                e.im = nar(hi + ii);
                m_fifo.push_back({nar(hr - ir), nar(hi - ii)});
                m_primed = 1;
            end
            m_cnt = (m_cnt + 1) % (2 * D);
        end
        exp_q.push_back(e);
        in_valid = v;
        in_re = re;
        in_im = im;
        @(posedge clk);
        #1;
        got_q.push_back({out_valid, out_sop, out_re, out_im, tw_addr});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_re = 16'h1234;
        in_im = 16'h5678;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp += 5;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        if (out_sop !== 1'b0) begin n_bad++; $display("FAIL reset_sop got %b want 0", out_sop); end
        if (out_re !== '0) begin n_bad++; $display("FAIL reset_re got %h want 0", out_re); end
        if (out_im !== '0) begin n_bad++; $display("FAIL reset_im got %h want 0", out_im); end
        if (tw_addr !== '0) begin n_bad++; $display("FAIL reset_tw got %h want 0", tw_addr); end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_block();
        obs_t g;
        exp_q = {};
        got_q = {};
        do_reset();
        for (int i = 1; i <= 8; i++) drive(1'b1, W'(i), '0);
        for (int i = 0; i < 4; i++) drive(1'b1, '0, '0);
        for (int i = 0; i < 12; i++) begin
            g = got_q.pop_front();
            n_cmp++;
            if (g.v !== (i >= 4) || (i >= 4 && (g.re !== ref_re[i-4] || g.im !== '0 || g.tw !== ref_tw[i-4] || g.sop !== (i == 4)))) begin
                n_bad++;
                $display("FAIL block cyc%0d got v=%b re=%h im=%h tw=%0d sop=%b want v=%b re=%h tw=%0d sop=%b",
                         i, g.v, g.re, g.im, g.tw, g.sop, i >= 4, i >= 4 ? ref_re[i-4] : 16'h0, i >= 4 ? ref_tw[i-4] : 2'd0, i == 4);
            end
        end
        exp_q = {};
    endtask

    task automatic test_gaps();
        obs_t e, g;
        exp_q = {};
        got_q = {};
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            drive(1'b1, i <= 8 ? W'(i) : '0, '0);
            drive(1'b0, W'($urandom), W'($urandom));
        end
        for (int i = 0; i < 24; i++) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_cmp++;
            if (g.v !== e.v || (e.v && (g.re !== e.re || g.im !== e.im || g.tw !== e.tw || g.sop !== e.sop))) begin
                n_bad++;
                $display("FAIL gaps cyc%0d got v=%b re=%h im=%h tw=%0d sop=%b want v=%b re=%h im=%h tw=%0d sop=%b",
                         i, g.v, g.re, g.im, g.tw, g.sop, e.v, e.re, e.im, e.tw, e.sop);
            end
        end
    endtask

    task automatic test_headroom();
        obs_t e, g;
        exp_q = {};
        got_q = {};
        do_reset();
        for (int i = 0; i < 12; i++) drive(1'b1, (i == 0 || i == 4) ? 16'h7FFF : '0, '0);
        n_cmp += 2;
        if (got_q[4].re !== wrap_sum) begin n_bad++; $display("FAIL headroom_sum got %h want %h", got_q[4].re, wrap_sum); end
        if (got_q[8].re !== '0) begin n_bad++; $display("FAIL headroom_diff got %h want 0", got_q[8].re); end
        for (int i = 0; i < 12; i++) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_cmp++;
            if (g.v !== e.v || (e.v && (g.re !== e.re || g.im !== e.im || g.tw !== e.tw || g.sop !== e.sop))) begin
                n_bad++;
                $display("FAIL headroom cyc%0d got v=%b re=%h tw=%0d want v=%b re=%h tw=%0d", i, g.v, g.re, g.tw, e.v, e.re, e.tw);
            end
        end
    endtask

    task automatic test_reset_mid_block();
        obs_t g;
        exp_q = {};
        got_q = {};
        do_reset();
        for (int i = 1; i <= 6; i++) drive(1'b1, W'(100 + i), W'(i));
        do_reset();
        got_q = {};
        for (int i = 1; i <= 8; i++) drive(1'b1, W'(i), '0);
        for (int i = 0; i < 4; i++) drive(1'b1, '0, '0);
        for (int i = 0; i < 12; i++) begin
            g = got_q.pop_front();
            n_cmp++;
            if (g.v !== (i >= 4) || (i >= 4 && (g.re !== ref_re[i-4] || g.im !== '0 || g.tw !== ref_tw[i-4] || g.sop !== (i == 4)))) begin
                n_bad++;
                $display("FAIL midreset cyc%0d got v=%b re=%h im=%h tw=%0d sop=%b want re=%h tw=%0d",
                         i, g.v, g.re, g.im, g.tw, g.sop, i >= 4 ? ref_re[i-4] : 16'h0, i >= 4 ? ref_tw[i-4] : 2'd0);
            end
        end
        exp_q = {};
    endtask

    task automatic test_random();
        obs_t e, g;
        int bad0;
        exp_q = {};
        got_q = {};
        bad0 = n_bad;
        do_reset();
        for (int i = 0; i < 64 * 2 * D + D; i++) begin
            if ($urandom_range(3) == 0) drive(1'b0, W'($urandom), W'($urandom));
            drive(1'b1, W'($urandom), W'($urandom));
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_cmp++;
            if ((g.v !== e.v || (e.v && (g.re !== e.re || g.im !== e.im || g.tw !== e.tw || g.sop !== e.sop))) && n_bad - bad0 < 10) begin
                n_bad++;
                $display("FAIL random got v=%b re=%h im=%h tw=%0d sop=%b want v=%b re=%h im=%h tw=%0d sop=%b",
                         g.v, g.re, g.im, g.tw, g.sop, e.v, e.re, e.im, e.tw, e.sop);
            end else if (g.v !== e.v || (e.v && (g.re !== e.re || g.im !== e.im || g.tw !== e.tw || g.sop !== e.sop))) begin
                n_bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_block();
        test_gaps();
        test_headroom();
        test_reset_mid_block();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
